// File: rtl/forward_hazard_unit_pkg.sv
// Shared DLX definitions for the forwarding/hazard unit: operand source
// codes and the load-use stall FSM state encoding.
package forward_hazard_unit_pkg;

    localparam logic [1:0] FWD_SEL_REG  = 2'd0;
    localparam logic [1:0] FWD_SEL_MEM  = 2'd1;
    localparam logic [1:0] FWD_SEL_WB   = 2'd2;
    localparam logic [1:0] FWD_SEL_HIST = 2'd3;

    localparam int          STALL_CNT_W     = 3;
    localparam logic [15:0] STALL_COUNT_MAX = 16'hFFFF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/forward_hazard_unit_fwd_port_mux.sv
// Priority operand select for one EX port: MEM, then WB, then retired-write
// history (newest first), falling back to the register-file value.
module fwd_port_mux
    import forward_hazard_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int HIST_DEPTH     = 2,
    parameter bit ZERO_REG_EN    = 1'b1
) (
    input  logic [DATA_WIDTH-1:0]                     rf_data,
    input  logic [REG_ADDR_WIDTH-1:0]                 addr,
    input  logic [DATA_WIDTH-1:0]                     mem_data,
    input  logic [REG_ADDR_WIDTH-1:0]                 mem_addr,
    input  logic                                      mem_wr_ena,
    input  logic [DATA_WIDTH-1:0]                     wb_data,
    input  logic [REG_ADDR_WIDTH-1:0]                 wb_addr,
    input  logic                                      wb_wr_ena,
    input  logic [HIST_DEPTH-1:0][REG_ADDR_WIDTH-1:0] hist_addr,
    input  logic [HIST_DEPTH-1:0][DATA_WIDTH-1:0]     hist_data,
    input  logic [HIST_DEPTH-1:0]                     hist_valid,
    output logic [DATA_WIDTH-1:0]                     data,
    output logic [1:0]                                sel
);

    always_comb begin
        data = rf_data;
        sel  = FWD_SEL_REG;
        if (!(ZERO_REG_EN && addr == '0)) begin
            if (mem_wr_ena && mem_addr == addr) begin
                data = mem_data;
                sel  = FWD_SEL_MEM;
            end else if (wb_wr_ena && wb_addr == addr) begin
                data = wb_data;
                sel  = FWD_SEL_WB;
            end else begin
                // Walk oldest to newest so the newest matching entry wins.
                for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
                    if (hist_valid[i] && hist_addr[i] == addr) begin
                        data = hist_data[i];
                        sel  = FWD_SEL_HIST;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding with a short retired-write history, plus load-use
// hazard detection that freezes IF/ID and bubbles ID/EX for LOAD_LATENCY cycles.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_PORTS      = 2,
    parameter int HIST_DEPTH     = 2,
    parameter int LOAD_LATENCY   = 1,
    parameter bit ZERO_REG_EN    = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     ex_data_in,
    input  logic [NUM_PORTS*REG_ADDR_WIDTH-1:0] ex_addr_in,
    input  logic [NUM_PORTS*REG_ADDR_WIDTH-1:0] id_addr_in,
    input  logic [NUM_PORTS-1:0]                id_rd_ena_in,
    input  logic [REG_ADDR_WIDTH-1:0]           id_ex_reg_addr_in,
    input  logic                                id_ex_reg_wr_ena_in,
    input  logic                                id_ex_is_load_in,
    input  logic [DATA_WIDTH-1:0]               ex_mem_data_in,
    input  logic [REG_ADDR_WIDTH-1:0]           ex_mem_reg_addr_in,
    input  logic                                ex_mem_reg_wr_ena_in,
    input  logic [DATA_WIDTH-1:0]               wb_reg_data_in,
    input  logic [REG_ADDR_WIDTH-1:0]           wb_reg_addr_in,
    input  logic                                wb_reg_wr_ena_in,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]     ex_data_out,
    output logic [NUM_PORTS*2-1:0]              fwd_sel_out,
    output logic                                stall_out,
    output logic                                flush_ex_out,
    output logic [15:0]                         stall_count_out
);

    logic [HIST_DEPTH-1:0][REG_ADDR_WIDTH-1:0] hist_addr;
    logic [HIST_DEPTH-1:0][DATA_WIDTH-1:0]     hist_data;
    logic [HIST_DEPTH-1:0]                     hist_valid;
    logic                                      hist_push;

    fsm_state_t             state;
    logic [STALL_CNT_W-1:0] cnt;
    logic                   load_use;

    assign hist_push = wb_reg_wr_ena_in && !(ZERO_REG_EN && wb_reg_addr_in == '0);

    // History payload carries no reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (hist_push) begin
            for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                hist_addr[i] <= hist_addr[i-1];
                hist_data[i] <= hist_data[i-1];
            end
            hist_addr[0] <= wb_reg_addr_in;
            hist_data[0] <= wb_reg_data_in;
        end
    end

    for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_hist_valid
        if (g == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst)            hist_valid[0] <= 1'b0;
                else if (hist_push) hist_valid[0] <= 1'b1;
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (rst)            hist_valid[g] <= 1'b0;
                else if (hist_push) hist_valid[g] <= hist_valid[g-1];
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        fwd_port_mux #(
            .DATA_WIDTH    (DATA_WIDTH),
            .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
            .HIST_DEPTH    (HIST_DEPTH),
            .ZERO_REG_EN   (ZERO_REG_EN)
        ) u_mux (
            .rf_data   (ex_data_in[p*DATA_WIDTH +: DATA_WIDTH]),
            .addr      (ex_addr_in[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
            .mem_data  (ex_mem_data_in),
            .mem_addr  (ex_mem_reg_addr_in),
            .mem_wr_ena(ex_mem_reg_wr_ena_in),
            .wb_data   (wb_reg_data_in),
            .wb_addr   (wb_reg_addr_in),
            .wb_wr_ena (wb_reg_wr_ena_in),
            .hist_addr (hist_addr),
            .hist_data (hist_data),
            .hist_valid(hist_valid),
            .data      (ex_data_out[p*DATA_WIDTH +: DATA_WIDTH]),
            .sel       (fwd_sel_out[p*2 +: 2])
        );
    end

    always_comb begin
        load_use = 1'b0;
        if (id_ex_is_load_in && id_ex_reg_wr_ena_in && id_ex_reg_addr_in != '0) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (id_rd_ena_in[p] && id_addr_in[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == id_ex_reg_addr_in)
                    load_use = 1'b1;
            end
        end
    end

    // The detect cycle itself is the first stall cycle; STALL covers the rest.
    assign stall_out    = !rst && (state == ST_STALL || load_use);
    assign flush_ex_out = stall_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_use && LOAD_LATENCY > 1) begin
                        cnt   <= STALL_CNT_W'(LOAD_LATENCY - 1);
                        state <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == STALL_CNT_W'(1)) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_count_out <= '0;
        else if (stall_out && stall_count_out != STALL_COUNT_MAX)
            stall_count_out <= stall_count_out + 16'd1;
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit: directed scenarios plus
// randomized traffic compared every cycle against a queue-based model.
module tb_forward_hazard_unit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;
    localparam int HD = 2;
    localparam int LL = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NP*DW-1:0]     ex_data_in;
    logic [NP*AW-1:0]     ex_addr_in;
    logic [NP*AW-1:0]     id_addr_in;
    logic [NP-1:0]        id_rd_ena_in;
    logic [AW-1:0]        id_ex_reg_addr_in;
    logic                 id_ex_reg_wr_ena_in;
    logic                 id_ex_is_load_in;
    logic [DW-1:0]        ex_mem_data_in;
    logic [AW-1:0]        ex_mem_reg_addr_in;
    logic                 ex_mem_reg_wr_ena_in;
    logic [DW-1:0]        wb_reg_data_in;
    logic [AW-1:0]        wb_reg_addr_in;
    logic                 wb_reg_wr_ena_in;
    logic [NP*DW-1:0]     ex_data_out;
    logic [NP*2-1:0]      fwd_sel_out;
    logic                 stall_out;
    logic                 flush_ex_out;
    logic [15:0]          stall_count_out;

    int checks = 0;
    int fails  = 0;
    bit run    = 1'b0;

    // Reference model state: newest history write at index 0.
    logic [AW+DW-1:0] hq[$];
    int               rem    = 0;
    int               scount = 0;

    forward_hazard_unit #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_PORTS(NP),
        .HIST_DEPTH(HD), .LOAD_LATENCY(LL), .ZERO_REG_EN(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .ex_data_in(ex_data_in), .ex_addr_in(ex_addr_in),
        .id_addr_in(id_addr_in), .id_rd_ena_in(id_rd_ena_in),
        .id_ex_reg_addr_in(id_ex_reg_addr_in), .id_ex_reg_wr_ena_in(id_ex_reg_wr_ena_in),
        .id_ex_is_load_in(id_ex_is_load_in),
        .ex_mem_data_in(ex_mem_data_in), .ex_mem_reg_addr_in(ex_mem_reg_addr_in),
        .ex_mem_reg_wr_ena_in(ex_mem_reg_wr_ena_in),
        .wb_reg_data_in(wb_reg_data_in), .wb_reg_addr_in(wb_reg_addr_in),
        .wb_reg_wr_ena_in(wb_reg_wr_ena_in),
        .ex_data_out(ex_data_out), .fwd_sel_out(fwd_sel_out),
        .stall_out(stall_out), .flush_ex_out(flush_ex_out),
        .stall_count_out(stall_count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_detect();
        bit hit = 1'b0;
        if (id_ex_is_load_in && id_ex_reg_wr_ena_in && id_ex_reg_addr_in != 0)
            for (int p = 0; p < NP; p++)
                if (id_rd_ena_in[p] && id_addr_in[p*AW +: AW] == id_ex_reg_addr_in) hit = 1'b1;
        return hit;
    endfunction

    function automatic bit m_stall();
        return !rst && (rem > 0 || m_detect());
    endfunction

    function automatic void m_port(input int p, output logic [DW-1:0] d, output logic [1:0] s);
        logic [AW-1:0] a;
        a = ex_addr_in[p*AW +: AW];
        d = ex_data_in[p*DW +: DW];
        s = 2'd0;
        if (a == 0) return;
        if (ex_mem_reg_wr_ena_in && ex_mem_reg_addr_in == a) begin
            d = ex_mem_data_in; s = 2'd1; return;
        end
        if (wb_reg_wr_ena_in && wb_reg_addr_in == a) begin
            d = wb_reg_data_in; s = 2'd2; return;
        end
        foreach (hq[i]) begin
            if (hq[i][AW+DW-1:DW] == a) begin
                d = hq[i][DW-1:0]; s = 2'd3; return;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hq.delete();
            rem    <= 0;
            scount <= 0;
        end else begin
            if (m_stall() && scount < 65535) scount <= scount + 1;
            if (rem > 0)         rem <= rem - 1;
            else if (m_detect()) rem <= LL - 1;
            if (wb_reg_wr_ena_in && wb_reg_addr_in != 0) begin
                hq.push_front({wb_reg_addr_in, wb_reg_data_in});
                if (hq.size() > HD) void'(hq.pop_back());
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            logic [DW-1:0] ed;
            logic [1:0]    es;
            for (int p = 0; p < NP; p++) begin
                m_port(p, ed, es);
                chk($sformatf("model_data%0d", p), 64'(ex_data_out[p*DW +: DW]), 64'(ed));
                chk($sformatf("model_sel%0d", p), 64'(fwd_sel_out[p*2 +: 2]), 64'(es));
            end
            chk("model_stall", 64'(stall_out), 64'(m_stall()));
            chk("model_flush", 64'(flush_ex_out), 64'(m_stall()));
            chk("model_stall_count", 64'(stall_count_out), 64'(scount));
        end
    end

    task automatic clear_inputs();
        ex_data_in           = {$urandom, $urandom};
        ex_addr_in           = '0;
        id_addr_in           = '0;
        id_rd_ena_in         = '0;
        id_ex_reg_addr_in    = '0;
        id_ex_reg_wr_ena_in  = 1'b0;
        id_ex_is_load_in     = 1'b0;
        ex_mem_data_in       = '0;
        ex_mem_reg_addr_in   = '0;
        ex_mem_reg_wr_ena_in = 1'b0;
        wb_reg_data_in       = '0;
        wb_reg_addr_in       = '0;
        wb_reg_wr_ena_in     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_r4();
        id_ex_is_load_in    = 1'b1;
        id_ex_reg_wr_ena_in = 1'b1;
        id_ex_reg_addr_in   = 5'd4;
        id_addr_in[0 +: AW] = 5'd4;
        id_rd_ena_in        = 2'b01;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        clear_inputs();
        run = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", 64'(stall_out), 64'd0);
        chk("reset_count", 64'(stall_count_out), 64'd0);

        // MEM beats WB on the same register
        tick();
        ex_mem_reg_wr_ena_in = 1'b1; ex_mem_reg_addr_in = 5'd3; ex_mem_data_in = 32'hAAAA0001;
        wb_reg_wr_ena_in = 1'b1;     wb_reg_addr_in = 5'd3;     wb_reg_data_in = 32'h5;
        ex_addr_in[0 +: AW] = 5'd3;
        @(negedge clk);
        chk("mem_prio_data", 64'(ex_data_out[0 +: DW]), 64'hAAAA0001);
        chk("mem_prio_sel", 64'(fwd_sel_out[1:0]), 64'd1);

        // r0 is never forwarded
        tick();
        clear_inputs();
        ex_data_in[DW +: DW] = 32'h12345678;
        ex_mem_reg_wr_ena_in = 1'b1; ex_mem_reg_addr_in = 5'd0; ex_mem_data_in = 32'hFFFF;
        wb_reg_wr_ena_in = 1'b1;     wb_reg_addr_in = 5'd0;     wb_reg_data_in = 32'hFFFF;
        @(negedge clk);
        chk("r0_data", 64'(ex_data_out[DW +: DW]), 64'h12345678);
        chk("r0_sel", 64'(fwd_sel_out[3:2]), 64'd0);

        // newest duplicate in history wins
        tick();
        clear_inputs();
        wb_reg_wr_ena_in = 1'b1; wb_reg_addr_in = 5'd7; wb_reg_data_in = 32'h11;
        tick();
        wb_reg_data_in = 32'h22;
        tick();
        clear_inputs();
        ex_addr_in[0 +: AW] = 5'd7;
        @(negedge clk);
        chk("hist_newest_data", 64'(ex_data_out[0 +: DW]), 64'h22);
        chk("hist_newest_sel", 64'(fwd_sel_out[1:0]), 64'd3);

        // load-use stall lasts exactly LL cycles
        tick();
        do_reset();
        set_load_r4();
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (stall_out && flush_ex_out) n++;
            tick();
            if (c == 0) clear_inputs();
        end
        chk("stall_cycles", 64'(n), 64'd3);
        @(negedge clk);
        chk("stall_count_3", 64'(stall_count_out), 64'd3);

        // reset in the 2nd stall cycle aborts the stall and empties history
        tick();
        do_reset();
        wb_reg_wr_ena_in = 1'b1; wb_reg_addr_in = 5'd9; wb_reg_data_in = 32'h99;
        tick();
        clear_inputs();
        set_load_r4();
        tick();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        ex_addr_in[0 +: AW] = 5'd9;
        ex_data_in[0 +: DW] = 32'hCAFE0009;
        @(negedge clk);
        chk("abort_stall", 64'(stall_out), 64'd0);
        chk("abort_flush", 64'(flush_ex_out), 64'd0);
        chk("abort_count", 64'(stall_count_out), 64'd0);
        chk("abort_hist_sel", 64'(fwd_sel_out[1:0]), 64'd0);
        chk("abort_hist_data", 64'(ex_data_out[0 +: DW]), 64'hCAFE0009);

        // saturation of the stall counter
        tick();
        do_reset();
        set_load_r4();
        repeat (65540) tick();
        clear_inputs();
        @(negedge clk);
        chk("stall_count_sat", 64'(stall_count_out), 64'hFFFF);

        // randomized traffic, checked by the per-cycle model comparison
        tick();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rst                  = ($urandom_range(0, 63) == 0);
            ex_data_in           = {$urandom, $urandom};
            for (int p = 0; p < NP; p++) begin
                ex_addr_in[p*AW +: AW] = AW'($urandom_range(0, 7));
                id_addr_in[p*AW +: AW] = AW'($urandom_range(0, 7));
            end
            id_rd_ena_in         = NP'($urandom);
            id_ex_reg_addr_in    = AW'($urandom_range(0, 7));
            id_ex_reg_wr_ena_in  = 1'($urandom);
            id_ex_is_load_in     = ($urandom_range(0, 3) == 0);
            ex_mem_data_in       = $urandom;
            ex_mem_reg_addr_in   = AW'($urandom_range(0, 7));
            ex_mem_reg_wr_ena_in = 1'($urandom);
            wb_reg_data_in       = $urandom;
            wb_reg_addr_in       = AW'($urandom_range(0, 7));
            wb_reg_wr_ena_in     = 1'($urandom);
            tick();
        end

        run = 1'b0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
